// File: rtl/mtf_pkg.sv
// Shared types and helpers for the MTF spike post-processing blocks.
package mtf_pkg;

  typedef enum logic {
    StIdle    = 1'b0,
    StInBurst = 1'b1
  } state_e;

  localparam int unsigned CntWDefault  = 16;
  localparam int unsigned NspkWDefault = 8;

  // Increment v, holding at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load (clear wins over load over inc).
module sat_counter
  import mtf_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = WIDTH'(sat_inc(32'(q), WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/spike_burst_decoder.sv
// Groups spike rising edges into bursts and reports count, length and start-to-start period.
module spike_burst_decoder
  import mtf_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned NSPK_W     = NspkWDefault,
  parameter int unsigned GAP_MAX    = 40,
  parameter int unsigned MIN_SPIKES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spike,
  input  logic              burst_ready,
  output logic              burst_valid,
  output logic [NSPK_W-1:0] burst_nspk,
  output logic [CNT_W-1:0]  burst_len,
  output logic [CNT_W-1:0]  burst_period,
  output logic              period_ok,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              spike_q;
  logic              rise, in_burst, idle_rise, burst_rise, close, accept, take;
  logic [CNT_W-1:0]  age, gap, per_cnt, age_inc;
  logic [CNT_W-1:0]  last_q, cand_q;
  logic [NSPK_W-1:0] nspk;
  logic              have_ref_q;

  logic              valid_q, period_ok_q;
  logic [NSPK_W-1:0] nspk_q;
  logic [CNT_W-1:0]  len_q, period_q;
  logic [7:0]        drop_q;

  assign rise       = spike & ~spike_q;
  assign in_burst   = (state_q == StInBurst);
  assign idle_rise  = ~in_burst & rise;
  assign burst_rise = in_burst & rise;
  assign age_inc    = CNT_W'(sat_inc(32'(age), CNT_W));
  // A rise on the closing edge extends the burst instead of closing it.
  assign close      = in_burst & ~rise & (gap == CNT_W'(GAP_MAX - 1));
  assign accept     = close & (nspk >= NSPK_W'(MIN_SPIKES));
  assign take       = accept & (~valid_q | burst_ready);

  sat_counter #(.WIDTH(CNT_W)) u_age (
    .clk      (clk),
    .reset    (reset),
    .clr      (idle_rise),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_burst),
    .q        (age)
  );

  sat_counter #(.WIDTH(CNT_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .clr      (rise),
    .load     (1'b0),
    .load_val ('0),
    .inc      (in_burst & ~rise),
    .q        (gap)
  );

  sat_counter #(.WIDTH(NSPK_W)) u_nspk (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load     (idle_rise),
    .load_val (NSPK_W'(1)),
    .inc      (burst_rise),
    .q        (nspk)
  );

  // Cycles since the last accepted burst's first rise (or since reset).
  sat_counter #(.WIDTH(CNT_W)) u_per_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load     (accept),
    .load_val (age_inc),
    .inc      (1'b1),
    .q        (per_cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (rise) state_d = StInBurst;
      StInBurst: if (close) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_q     <= 1'b1;
      state_q     <= StIdle;
      last_q      <= '0;
      cand_q      <= '0;
      have_ref_q  <= 1'b0;
      valid_q     <= 1'b0;
      nspk_q      <= '0;
      len_q       <= '0;
      period_q    <= '0;
      period_ok_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      spike_q <= spike;
      state_q <= state_d;
      // The period edge itself is included, hence per_cnt + 1.
      if (idle_rise) begin
        last_q <= '0;
        cand_q <= CNT_W'(sat_inc(32'(per_cnt), CNT_W));
      end else if (burst_rise) begin
        last_q <= age_inc;
      end
      if (accept) have_ref_q <= 1'b1;
      if (take) begin
        valid_q     <= 1'b1;
        nspk_q      <= nspk;
        len_q       <= last_q;
        period_q    <= cand_q;
        period_ok_q <= have_ref_q;
      end else if (accept) begin
        drop_q <= 8'(sat_inc(32'(drop_q), 8));
      end else if (valid_q && burst_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign burst_valid  = valid_q;
  assign burst_nspk   = nspk_q;
  assign burst_len    = len_q;
  assign burst_period = period_q;
  assign period_ok    = period_ok_q;
  assign drop_cnt     = drop_q;
  assign busy         = in_burst;

endmodule

// File: tb/tb_spike_burst_decoder.sv
// Scoreboard bench: two decoders (MIN_SPIKES 1 and 2) share one stimulus stream.
module tb_spike_burst_decoder;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NSPK_W  = 8;
  localparam int          GAP_MAX = 40;
  localparam int          CNT_MAX = 65535;
  localparam int          NSP_MAX = 255;

  typedef struct {
    int nspk;
    int len;
    int period;
    int ok;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spike = 1'b0;
  logic burst_ready = 1'b1;
  bit   rnd_ready = 1'b0;

  logic              valid [2];
  logic [NSPK_W-1:0] nspk  [2];
  logic [CNT_W-1:0]  len   [2];
  logic [CNT_W-1:0]  period[2];
  logic              pok   [2];
  logic [7:0]        drop  [2];
  logic              busy  [2];

  int passes = 0;
  int total  = 0;

  res_t expq0[$];
  res_t expq1[$];

  // Reference model state
  int t = 0;
  bit prev = 1'b1;
  bit in_b[2];
  int first_r[2], last_r[2], cnt[2], ref_t[2], drops[2];
  bit have_ref[2], slot[2];
  int min_sp[2] = '{1, 2};

  always #5 clk = ~clk;

  spike_burst_decoder #(.MIN_SPIKES(1)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .spike        (spike),
    .burst_ready  (burst_ready),
    .burst_valid  (valid[0]),
    .burst_nspk   (nspk[0]),
    .burst_len    (len[0]),
    .burst_period (period[0]),
    .period_ok    (pok[0]),
    .drop_cnt     (drop[0]),
    .busy         (busy[0])
  );

  spike_burst_decoder #(.MIN_SPIKES(2)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .spike        (spike),
    .burst_ready  (burst_ready),
    .burst_valid  (valid[1]),
    .burst_nspk   (nspk[1]),
    .burst_len    (len[1]),
    .burst_period (period[1]),
    .period_ok    (pok[1]),
    .drop_cnt     (drop[1]),
    .busy         (busy[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Model: bursts from absolute rise times, single-slot output with backpressure.
  initial begin
    forever begin
      @(posedge clk);
      t++;
      if (reset) begin
        prev = 1'b1;
        for (int i = 0; i < 2; i++) begin
          in_b[i] = 0; ref_t[i] = t; have_ref[i] = 0; slot[i] = 0; drops[i] = 0;
        end
        expq0.delete();
        expq1.delete();
      end else begin
        bit rise;
        rise = spike && !prev;
        prev = spike;
        for (int i = 0; i < 2; i++) begin
          bit closing, loaded, hs;
          res_t r;
          closing = 0;
          loaded  = 0;
          hs      = slot[i] && burst_ready;
          if (in_b[i]) begin
            if (rise) begin
              cnt[i]++;
              last_r[i] = t;
            end else if (t - last_r[i] == GAP_MAX) begin
              closing = 1;
            end
          end else if (rise) begin
            in_b[i] = 1; first_r[i] = t; last_r[i] = t; cnt[i] = 1;
          end
          if (closing) begin
            in_b[i] = 0;
            if (cnt[i] >= min_sp[i]) begin
              r.nspk   = imin(cnt[i], NSP_MAX);
              r.len    = imin(last_r[i] - first_r[i], CNT_MAX);
              r.period = imin(first_r[i] - ref_t[i], CNT_MAX);
              r.ok     = have_ref[i];
              ref_t[i] = first_r[i];
              have_ref[i] = 1;
              if (!slot[i] || burst_ready) begin
                if (i == 0) expq0.push_back(r);
                else expq1.push_back(r);
                slot[i] = 1;
                loaded  = 1;
              end else begin
                drops[i] = imin(drops[i] + 1, 255);
              end
            end
          end
          if (!loaded && hs) slot[i] = 0;
        end
      end
    end
  end

  // Monitor: compare status every cycle, payload at each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (t > 0) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("valid%0d", i), int'(valid[i]), int'(slot[i]));
          chk($sformatf("busy%0d", i), int'(busy[i]), int'(in_b[i]));
          chk($sformatf("drop%0d", i), int'(drop[i]), drops[i]);
          if (!reset && valid[i] && burst_ready) begin
            res_t r;
            bit have;
            have = 0;
            if (i == 0 && expq0.size() > 0) begin r = expq0.pop_front(); have = 1; end
            if (i == 1 && expq1.size() > 0) begin r = expq1.pop_front(); have = 1; end
            if (!have) begin
              total++;
              $display("FAIL unexpected_burst%0d t=%0d actual=valid required=no result", i, t);
            end else begin
              chk($sformatf("nspk%0d", i), int'(nspk[i]), r.nspk);
              chk($sformatf("len%0d", i), int'(len[i]), r.len);
              chk($sformatf("period%0d", i), int'(period[i]), r.period);
              chk($sformatf("period_ok%0d", i), int'(pok[i]), r.ok);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) burst_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic spk(input int hi, input int lo);
    spike = 1'b1;
    repeat (hi) tick();
    spike = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      in_b[i] = 0; slot[i] = 0; drops[i] = 0; have_ref[i] = 0; ref_t[i] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_nspk", int'(nspk[i]), 0);
      chk("rst_len", int'(len[i]), 0);
      chk("rst_period", int'(period[i]), 0);
      chk("rst_pok", int'(pok[i]), 0);
    end
    repeat (5) tick();

    // Single spike held 3 cycles: result 40 edges after the rise edge.
    spike = 1'b1;
    tick();
    n = 0;
    while (!valid[0] && n < 100) begin
      if (n == 2) spike = 1'b0;
      tick();
      n++;
    end
    spike = 1'b0;
    chk("single_latency", n, GAP_MAX);
    repeat (10) tick();

    // Four rises 10 apart, next burst 200 after the first.
    repeat (3) spk(1, 9);
    spk(1, 169);
    spk(1, 60);

    // Gap exactly GAP_MAX extends; GAP_MAX+1 splits.
    spk(1, GAP_MAX - 1);
    spk(1, 60);
    spk(1, GAP_MAX);
    spk(1, 60);

    // Backpressure: hold, drop, then ready on a closing edge.
    burst_ready = 1'b0;
    spk(1, 60);
    spk(1, 60);
    chk("bp_drop", int'(drop[0]), 1);
    spk(1, GAP_MAX - 1);
    burst_ready = 1'b1;
    tick();
    burst_ready = 1'b0;
    chk("bp_valid_kept", int'(valid[0]), 1);
    chk("bp_drop_same", int'(drop[0]), 1);
    repeat (5) tick();
    burst_ready = 1'b1;
    repeat (5) tick();

    // MIN_SPIKES=2 instance: isolated spike rejected, triple accepted.
    do_reset();
    repeat (4) tick();
    spk(1, 60);
    spk(2, 5);
    spk(1, 5);
    spk(1, 60);

    // Reset mid-burst with spike held through release.
    spk(1, 5);
    spike = 1'b1;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_busy", int'(busy[i]), 0);
      chk("mid_rst_valid", int'(valid[i]), 0);
      chk("mid_rst_nspk", int'(nspk[i]), 0);
      chk("mid_rst_drop", int'(drop[i]), 0);
    end
    spike = 1'b0;
    repeat (60) tick();

    // Randomized traffic with random backpressure and rare resets.
    rnd_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int hi, lo;
      hi = $urandom_range(1, 3);
      lo = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 50) : $urandom_range(1, 15);
      if ($urandom_range(0, 9) == 0) lo = 60;
      spk(hi, lo);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    rnd_ready = 1'b0;
    burst_ready = 1'b1;
    spike = 1'b0;
    repeat (80) tick();
    chk("drain0", expq0.size(), 0);
    chk("drain1", expq1.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
